sseg_mux_n: RTL and testbench

//  Parametrised N-digit seven-segment scan driver: hex decode, digit multiplexing, per-digit DP,

---
 rtl/sseg_mux_n.sv | 136 +++++++++++++
 tb/tb_sseg_mux_n.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sseg_mux_n.sv
// rtl/sseg_mux_n.sv - N-digit seven-segment scan driver with double-buffered frame, LZ blanking and PWM
module sseg_mux_n #(
  parameter int N_DIG      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int PWM_W      = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4*N_DIG-1:0] hex_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic               load,
  input  logic               lz_en,
  input  logic [PWM_W-1:0]   bright,
  output logic [N_DIG-1:0]   an,
  output logic [7:0]         sseg,
  output logic               frame_tick
);

  localparam int   DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int   IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic INV   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [4*N_DIG-1:0] shadow_hex_q, shadow_hex_d, active_hex_q, active_hex_d;
  logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic               pend_q, pend_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic               frame_tick_q, frame_tick_d;

  logic               slot_tick, boundary, on, all_zero, dp_sel, blank_sel;
  logic [N_DIG-1:0]   blank, an_raw;
  logic [3:0]         nib;
  logic [7:0]         seg_raw;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    slot_tick    = (div_cnt_q == DIV_W'(TICK_DIV - 1));
    boundary     = slot_tick && (idx_q == IDX_W'(N_DIG - 1));
    div_cnt_d    = slot_tick ? '0 : div_cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_tick) idx_d = boundary ? '0 : idx_q + 1'b1;
    pwm_cnt_d    = pwm_cnt_q + 1'b1;
    frame_tick_d = boundary;
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    active_hex_d = active_hex_q;
    active_dp_d  = active_dp_q;
    pend_d       = pend_q;
    // A load on the boundary edge bypasses the shadow so it is not lost a frame late.
    if (load) begin
      shadow_hex_d = hex_in;
      shadow_dp_d  = dp_in;
      if (boundary) begin
        active_hex_d = hex_in;
        active_dp_d  = dp_in;
        pend_d       = 1'b0;
      end else begin
        pend_d       = 1'b1;
      end
    end else if (boundary && pend_q) begin
      active_hex_d = shadow_hex_q;
      active_dp_d  = shadow_dp_q;
      pend_d       = 1'b0;
    end
  end

  always_comb begin
    on       = (pwm_cnt_q < bright) || (bright == '1);
    blank    = '0;
    all_zero = 1'b1;
    for (int i = N_DIG - 1; i > 0; i--) begin
      all_zero = all_zero && (active_hex_q[4*i +: 4] == 4'h0);
      blank[i] = lz_en && all_zero;
    end
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = active_hex_q[4*i +: 4];
        dp_sel    = active_dp_q[i];
        blank_sel = blank[i];
        an_raw[i] = on;
      end
    end
    seg_raw = on ? {dp_sel, (blank_sel ? 7'h00 : seg7(nib))} : 8'h00;
    an_d    = INV ? ~an_raw : an_raw;
    sseg_d  = INV ? ~seg_raw : seg_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pwm_cnt_q    <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      active_hex_q <= '0;
      active_dp_q  <= '0;
      pend_q       <= 1'b0;
      an_q         <= {N_DIG{INV}};
      sseg_q       <= {8{INV}};
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pwm_cnt_q    <= pwm_cnt_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      active_hex_q <= active_hex_d;
      active_dp_q  <= active_dp_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_n.sv
// tb/tb_sseg_mux_n.sv - randomized bench for sseg_mux_n against a cycle-count reference model
module tb_sseg_mux_n;
  localparam int ND = 4;
  localparam int TD = 4;
  localparam int FR = ND * TD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int          n_checks = 0;
  int          n_fail = 0;
  int          k = 0;
  int          lit;
  logic [15:0] m_hex, s_hex;
  logic [3:0]  m_dp, s_dp;
  logic        m_pend;
  logic [6:0]  seg_tbl [16];

  sseg_mux_n #(.N_DIG(ND), .TICK_DIV(TD), .PWM_W(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .bright(bright), .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // Expected outputs come from the cycle count since reset: slot = k/TD, digit = slot mod ND, pwm = k mod 16.
  task automatic step();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft, on, blank, bnd;
    logic [6:0] g;
    int         idx;
    if (reset) begin
      e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
      k = 0; m_hex = '0; m_dp = '0; s_hex = '0; s_dp = '0; m_pend = 1'b0;
    end else begin
      idx   = (k / TD) % ND;
      on    = (bright == 4'hF) || ((k % 16) < int'(bright));
      bnd   = (k % FR) == FR - 1;
      e_ft  = bnd;
      blank = lz_en && idx > 0 && ((m_hex >> (4 * idx)) == 16'h0);
      g     = blank ? 7'h00 : seg_tbl[m_hex[4*idx +: 4]];
      e_an  = on ? ~(4'b0001 << idx) : 4'hF;
      e_seg = on ? ~{m_dp[idx], g} : 8'hFF;
      if (load) begin
        s_hex = hex_in; s_dp = dp_in;
        if (bnd) begin m_hex = hex_in; m_dp = dp_in; m_pend = 1'b0; end
        else m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_hex = s_hex; m_dp = s_dp; m_pend = 1'b0;
      end
      k++;
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(e_an));
    check("sseg", 32'(sseg), 32'(e_seg));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("pend", 32'(dut.pend_q), 32'(m_pend));
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d);
    hex_in = h; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset = 1'b1; hex_in = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0; bright = 4'hF;
    step(); step();
    reset = 1'b0;

    do_load(16'h12AF, 4'b0100);
    repeat (3 * FR) step();

    repeat (5) step();
    do_load(16'h0000, 4'b0000);
    step();
    do_load(16'h0042, 4'b0001);
    repeat (2 * FR) step();

    while ((k % FR) != FR - 1) step();
    do_load(16'h9C3E, 4'b1010);
    check("pend_after_bnd_load", 32'(dut.pend_q), 32'd0);
    repeat (FR) step();

    lz_en = 1'b1;
    do_load(16'h0007, 4'b0000);
    repeat (2 * FR) step();
    do_load(16'h0000, 4'b0010);
    repeat (2 * FR) step();
    lz_en = 1'b0;

    bright = 4'h0; lit = 0;
    repeat (64) begin step(); if (an != 4'hF) lit++; end
    check("lit_b0", 32'(lit), 32'd0);
    bright = 4'h4; lit = 0;
    repeat (64) begin step(); if (an != 4'hF) lit++; end
    check("lit_b4", 32'(lit), 32'd16);
    bright = 4'hF; lit = 0;
    repeat (64) begin step(); if (an != 4'hF) lit++; end
    check("lit_bF", 32'(lit), 32'd64);

    repeat (800) begin
      bright = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 7) == 0) begin
        hex_in = 16'($urandom);
        if ($urandom_range(0, 3) == 0) hex_in[15:8] = 8'h00;
        dp_in = 4'($urandom);
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end

    bright = 4'hF;
    while (!(((k / TD) % ND) == 2 && (k % TD) == 1)) step();
    do_load(16'h5555, 4'b1111);
    reset = 1'b1;
    step();
    check("rst_idx", 32'(dut.idx_q), 32'd0);
    reset = 1'b0;
    repeat (2 * FR) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
